// File: rtl/dr_motion_sequencer.sv
// Rover drive-control stage: conditions the input-control command word and
// sequences both motors through a ramped FSM with PWM and direction outputs.
module dr_motion_sequencer #(
  parameter int PWM_PERIOD    = 1000,
  parameter int RAMP_STEP     = 10,
  parameter int RAMP_DIV      = 1000,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] state,
  input  logic       end_reset,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       dir_l,
  output logic       dir_r,
  output logic       brake_out,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    BRAKE     = 3'd4
  } fsm_t;

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [15:0]       PERIOD_M1 = 16'(PWM_PERIOD - 1);
  localparam logic [15:0]       STEP16    = 16'(RAMP_STEP);
  localparam logic [DIV_W-1:0]  DIV_M1    = DIV_W'(RAMP_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_M1   = STAB_W'(STABLE_CYCLES - 1);

  logic [7:0]        word_s1, word_s2, word_prev;
  logic              er_s1, er_s2;
  logic [STAB_W-1:0] stab_cnt;
  logic [6:0]        cmd;
  logic [DIV_W-1:0]  div_cnt;
  logic              ramp_tick;
  logic [15:0]       duty, ramp_target, target, active_duty, pwm_cnt;
  logic [16:0]       duty_up;
  logic              down_hits_target;
  logic              motion;
  logic [1:0]        dir_cmd;
  fsm_t              fsm;

  assign fsm_state = fsm;

  // stab_cnt holds how many cycles word_s2 has carried its current value
  always_ff @(posedge clk) begin
    if (rst) begin
      word_s1   <= '0;
      word_s2   <= '0;
      word_prev <= '0;
      er_s1     <= 1'b0;
      er_s2     <= 1'b0;
      stab_cnt  <= '0;
      cmd       <= '0;
    end else begin
      word_s1   <= state;
      word_s2   <= word_s1;
      word_prev <= word_s2;
      er_s1     <= end_reset;
      er_s2     <= er_s1;
      if (word_s2 != word_prev) begin
        stab_cnt <= STAB_W'(1);
        if (STABLE_CYCLES <= 1) cmd <= word_s2[6:0];
      end else if (stab_cnt >= STAB_M1) begin
        cmd <= word_s2[6:0];
      end else begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end
    end
  end

  always_comb begin
    motion  = 1'b1;
    dir_cmd = 2'b11;
    case (cmd[3:0])
      4'b0001: dir_cmd = 2'b11;
      4'b0010: dir_cmd = 2'b00;
      4'b0100: dir_cmd = 2'b01;
      4'b1000: dir_cmd = 2'b10;
      default: motion  = 1'b0;
    endcase
  end

  assign target  = 16'((18'(PWM_PERIOD) * (18'(cmd[5:4]) + 18'd1)) >> 2);
  assign duty_up = {1'b0, duty} + {1'b0, STEP16};
  assign down_hits_target = ({1'b0, duty} <= ({1'b0, ramp_target} + {1'b0, STEP16}));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      ramp_tick <= 1'b0;
    end else if (div_cnt == DIV_M1) begin
      div_cnt   <= '0;
      ramp_tick <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
      ramp_tick <= 1'b0;
    end
  end

  // Hold/brake override everything; directions may only be reloaded from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      duty        <= '0;
      ramp_target <= '0;
      dir_l       <= 1'b1;
      dir_r       <= 1'b1;
      brake_out   <= 1'b0;
      busy        <= 1'b0;
    end else if (er_s2 || cmd[6]) begin
      fsm       <= BRAKE;
      duty      <= '0;
      brake_out <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          if (motion) begin
            {dir_l, dir_r} <= dir_cmd;
            ramp_target    <= target;
            fsm            <= RAMP_UP;
            busy           <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (duty == ramp_target) begin
            fsm <= RUN;
          end else if (ramp_tick) begin
            duty <= (duty_up >= {1'b0, ramp_target}) ? ramp_target : duty_up[15:0];
          end
        end
        RUN: begin
          if (!motion || (dir_cmd != {dir_l, dir_r})) begin
            ramp_target <= '0;
            fsm         <= RAMP_DOWN;
          end else if (target > duty) begin
            ramp_target <= target;
            fsm         <= RAMP_UP;
          end else if (target < duty) begin
            ramp_target <= target;
            fsm         <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          if (duty == ramp_target) begin
            if (duty == 16'd0) begin
              fsm  <= IDLE;
              busy <= 1'b0;
            end else begin
              fsm <= RUN;
            end
          end else if (ramp_tick) begin
            duty <= down_hits_target ? ramp_target : (duty - STEP16);
          end
        end
        BRAKE: begin
          if (!motion) begin
            fsm       <= IDLE;
            brake_out <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          fsm       <= IDLE;
          duty      <= '0;
          brake_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Duty is only adopted at the period boundary so a period is never cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt     <= '0;
      active_duty <= '0;
      pwm_l       <= 1'b0;
      pwm_r       <= 1'b0;
    end else begin
      if (pwm_cnt == PERIOD_M1) begin
        pwm_cnt     <= '0;
        active_duty <= duty;
      end else begin
        pwm_cnt <= pwm_cnt + 16'd1;
      end
      pwm_l <= (pwm_cnt < active_duty);
      pwm_r <= (pwm_cnt < active_duty);
    end
  end

endmodule

// File: tb/tb_dr_motion_sequencer.sv
// Scoreboard bench for dr_motion_sequencer: a state-trajectory model queues the
// expected FSM transitions while a monitor checks each one as the DUT moves.
module tb_dr_motion_sequencer;

  localparam int PWM_PERIOD    = 20;
  localparam int RAMP_STEP     = 5;
  localparam int RAMP_DIV      = 4;
  localparam int STABLE_CYCLES = 3;
  localparam int SETTLE        = 100;

  localparam int S_IDLE  = 0;
  localparam int S_UP    = 1;
  localparam int S_RUN   = 2;
  localparam int S_DOWN  = 3;
  localparam int S_BRAKE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] state;
  logic       end_reset;
  logic       pwm_l, pwm_r, dir_l, dir_r, brake_out, busy;
  logic [2:0] fsm_state;

  dr_motion_sequencer #(
    .PWM_PERIOD   (PWM_PERIOD),
    .RAMP_STEP    (RAMP_STEP),
    .RAMP_DIV     (RAMP_DIV),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .end_reset(end_reset),
    .pwm_l    (pwm_l),
    .pwm_r    (pwm_r),
    .dir_l    (dir_l),
    .dir_r    (dir_r),
    .brake_out(brake_out),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       dl;
    logic       dr;
    logic       brk;
    logic       bsy;
  } event_t;

  event_t exp_q[$];
  int     checks   = 0;
  int     failures = 0;
  logic   mon_on   = 1'b0;

  int         m_st;
  logic [1:0] m_dir;
  int         m_duty;
  logic [7:0] m_word;
  logic       m_er;

  function automatic void checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endfunction

  function automatic bit is_motion(logic [7:0] w);
    return $countones(w[3:0]) == 1;
  endfunction

  function automatic logic [1:0] dir_of(logic [7:0] w);
    if (w[0]) return 2'b11;
    if (w[1]) return 2'b00;
    if (w[2]) return 2'b01;
    return 2'b10;
  endfunction

  function automatic int target_of(logic [7:0] w);
    return (PWM_PERIOD * (int'(w[5:4]) + 1)) / 4;
  endfunction

  function automatic void push(int st);
    event_t e;
    e.st  = 3'(st);
    e.dl  = m_dir[1];
    e.dr  = m_dir[0];
    e.brk = (st == S_BRAKE);
    e.bsy = (st != S_IDLE);
    exp_q.push_back(e);
  endfunction

  // Drives a held command and queues the state trajectory it should produce
  task automatic applyStimulus(input logic [7:0] bits, input logic er);
    logic [7:0] w;
    int         t;
    logic [1:0] d;
    w = {er, bits[6:0]};
    if (!er && m_st == S_BRAKE && m_er && !is_motion(m_word) && !m_word[6]) begin
      m_st = S_IDLE;
      push(S_IDLE);
    end
    if (er || w[6]) begin
      if (m_st != S_BRAKE) push(S_BRAKE);
      m_st   = S_BRAKE;
      m_duty = 0;
    end else if (m_st == S_BRAKE) begin
      if (!is_motion(w)) begin
        m_st = S_IDLE;
        push(S_IDLE);
      end
    end else if (is_motion(w)) begin
      t = target_of(w);
      d = dir_of(w);
      if (m_st == S_IDLE) begin
        m_dir = d;
        push(S_UP);
        push(S_RUN);
      end else if (d != m_dir) begin
        push(S_DOWN);
        push(S_IDLE);
        m_dir = d;
        push(S_UP);
        push(S_RUN);
      end else if (t > m_duty) begin
        push(S_UP);
        push(S_RUN);
      end else if (t < m_duty) begin
        push(S_DOWN);
        push(S_RUN);
      end
      m_st   = S_RUN;
      m_duty = t;
    end else if (m_st == S_RUN) begin
      push(S_DOWN);
      push(S_IDLE);
      m_st   = S_IDLE;
      m_duty = 0;
    end
    m_word    = w;
    m_er      = er;
    state     = w;
    end_reset = er;
  endtask

  task automatic settleAndCheck(string tag);
    int hi_l, hi_r, exp_hi;
    repeat (SETTLE) @(negedge clk);
    checkOutput({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    checkOutput({tag, "_fsm"}, int'(fsm_state), m_st);
    checkOutput({tag, "_dir"}, int'({dir_l, dir_r}), int'(m_dir));
    checkOutput({tag, "_brake"}, int'(brake_out), int'(m_st == S_BRAKE));
    checkOutput({tag, "_busy"}, int'(busy), int'(m_st != S_IDLE));
    hi_l = 0;
    hi_r = 0;
    repeat (2 * PWM_PERIOD) begin
      @(negedge clk);
      hi_l += int'(pwm_l);
      hi_r += int'(pwm_r);
    end
    exp_hi = (m_st == S_RUN) ? 2 * m_duty : 0;
    checkOutput({tag, "_pwm_l_high"}, hi_l, exp_hi);
    checkOutput({tag, "_pwm_r_high"}, hi_r, exp_hi);
  endtask

  initial begin
    logic [2:0] last;
    event_t     e;
    wait (mon_on);
    last = fsm_state;
    forever begin
      @(negedge clk);
      if (fsm_state != last) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_transition", int'(fsm_state), int'(last));
        end else begin
          e = exp_q.pop_front();
          checkOutput("transition", int'({fsm_state, dir_l, dir_r, brake_out, busy}), int'(e));
        end
        last = fsm_state;
      end
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [3:0] v;
    int         n;
    rst       = 1'b1;
    state     = 8'h00;
    end_reset = 1'b0;
    m_st      = S_IDLE;
    m_dir     = 2'b11;
    m_duty    = 0;
    m_word    = 8'h00;
    m_er      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_fsm", int'(fsm_state), S_IDLE);
    checkOutput("reset_dir", int'({dir_l, dir_r}), 3);
    checkOutput("reset_pwm", int'({pwm_l, pwm_r}), 0);
    checkOutput("reset_brake_busy", int'({brake_out, busy}), 0);
    mon_on = 1'b1;

    $display("[TB] forward speed 0");
    applyStimulus(8'h01, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("cmd_latency_ramp_up", int'(fsm_state), S_UP);
    settleAndCheck("fwd0");

    $display("[TB] full speed then reverse");
    applyStimulus(8'h31, 1'b0);
    settleAndCheck("fwd3");
    applyStimulus(8'h02, 1'b0);
    settleAndCheck("rev0");
    applyStimulus(8'h00, 1'b0);
    settleAndCheck("stop");

    $display("[TB] glitching command");
    for (int i = 0; i < 25; i++) begin
      state = (i % 2 == 0) ? 8'h01 : 8'h00;
      repeat (2) @(negedge clk);
    end
    state = 8'h00;
    settleAndCheck("glitch");

    $display("[TB] two motion bits");
    applyStimulus(8'h05, 1'b0);
    settleAndCheck("multi");

    $display("[TB] hold during run");
    applyStimulus(8'h21, 1'b0);
    settleAndCheck("fwd2");
    applyStimulus(8'h21, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("hold_latency_fsm", int'(fsm_state), S_BRAKE);
    checkOutput("hold_latency_brake", int'(brake_out), 1);
    settleAndCheck("hold");
    applyStimulus(8'h00, 1'b0);
    settleAndCheck("release");

    $display("[TB] reset mid ramp");
    m_dir = 2'b11;
    push(S_UP);
    state = 8'h31;
    n = 0;
    while (fsm_state != 3'(S_UP) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ramp_up_seen", int'(fsm_state), S_UP);
    repeat (6) @(negedge clk);
    state  = 8'h00;
    rst    = 1'b1;
    m_st   = S_IDLE;
    m_duty = 0;
    m_word = 8'h00;
    m_er   = 1'b0;
    push(S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midramp_reset_fsm", int'(fsm_state), S_IDLE);
    checkOutput("midramp_reset_outputs", int'({dir_l, dir_r, pwm_l, pwm_r, brake_out, busy}), 6'b110000);
    settleAndCheck("midramp");

    $display("[TB] randomized commands");
    for (int i = 0; i < 30; i++) begin
      b = 8'h01 << $urandom_range(0, 3);
      b[5:4] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: applyStimulus(b, 1'b1);
        1: applyStimulus(b | 8'h40, 1'b0);
        2: applyStimulus(8'h00, 1'b0);
        3: begin
          do v = 4'($urandom_range(0, 15)); while ($countones(v) < 2);
          b[3:0] = v;
          applyStimulus(b, 1'b0);
        end
        default: applyStimulus(b, 1'b0);
      endcase
      settleAndCheck("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
